// File: rtl/seq_monitor_pkg.sv
// Shared encodings for the sequence monitor: FSM states, upstream sequence values,
// and the legal-successor graph of the count-sequence FSM.
package seq_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        LOST  = 2'd3
    } state_e;

    localparam logic [2:0] SEQ_0 = 3'd0;
    localparam logic [2:0] SEQ_2 = 3'd2;
    localparam logic [2:0] SEQ_3 = 3'd3;
    localparam logic [2:0] SEQ_4 = 3'd4;
    localparam logic [2:0] SEQ_5 = 3'd5;

    function automatic logic is_legal_val(input logic [2:0] v);
        return (v == SEQ_0) || (v == SEQ_2) || (v == SEQ_3) ||
               (v == SEQ_4) || (v == SEQ_5);
    endfunction

    // Holding a value is never a legal step, so no node lists itself.
    function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] cur);
        logic ok;
        case (prev)
            SEQ_0:   ok = (cur == SEQ_3);
            SEQ_3:   ok = (cur == SEQ_2) || (cur == SEQ_5);
            SEQ_2:   ok = (cur == SEQ_4);
            SEQ_4:   ok = (cur == SEQ_3) || (cur == SEQ_0);
            SEQ_5:   ok = (cur == SEQ_2);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)
            q_d = '0;
        else if (inc && (q_q != {W{1'b1}}))
            q_d = q_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/seq_monitor.sv
// Checks the upstream count-sequence against its successor graph, tracks lock,
// counts laps and errors, and captures the first bad transition since clear.
module seq_monitor
    import seq_monitor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int SYNC_LEN = 2,
    parameter int ERR_THR  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       s_in,
    input  logic             s_valid,
    input  logic             clear,
    output logic             lock,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] lap_cnt,
    output logic [5:0]       first_bad,
    output logic [1:0]       state_o
);

    localparam int SW = $clog2(SYNC_LEN + 1);
    localparam int BW = $clog2(ERR_THR + 1);

    state_e        state_q, state_d;
    logic [2:0]    prev_q, prev_d;
    logic [SW-1:0] sync_run_q, sync_run_d;
    logic [BW-1:0] bad_run_q, bad_run_d;
    logic          pulse_q, pulse_d;
    logic          sticky_q, sticky_d;
    logic [5:0]    first_bad_q, first_bad_d;
    logic          err_inc, lap_inc;
    logic          step_ok, val_ok;
    logic [SW-1:0] sync_nxt;
    logic [BW-1:0] bad_nxt;

    assign step_ok  = is_legal_step(prev_q, s_in);
    assign val_ok   = is_legal_val(s_in);
    assign sync_nxt = sync_run_q + SW'(1);
    assign bad_nxt  = bad_run_q + BW'(1);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        sync_run_d  = sync_run_q;
        bad_run_d   = bad_run_q;
        pulse_d     = 1'b0;
        sticky_d    = sticky_q;
        first_bad_d = first_bad_q;
        err_inc     = 1'b0;
        lap_inc     = 1'b0;

        if (s_valid) begin
            case (state_q)
                IDLE: begin
                    if (val_ok) begin
                        state_d    = SYNC;
                        prev_d     = s_in;
                        sync_run_d = '0;
                    end
                end
                SYNC: begin
                    if (step_ok) begin
                        prev_d = s_in;
                        if (sync_nxt == SW'(SYNC_LEN)) begin
                            state_d    = TRACK;
                            sync_run_d = '0;
                            bad_run_d  = '0;
                        end else begin
                            sync_run_d = sync_nxt;
                        end
                    end else if (val_ok) begin
                        // A legal value on a bad step restarts the sync window from here.
                        prev_d     = s_in;
                        sync_run_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                TRACK: begin
                    if (step_ok) begin
                        prev_d    = s_in;
                        bad_run_d = '0;
                        lap_inc   = (prev_q == SEQ_4) && (s_in == SEQ_0);
                    end else begin
                        pulse_d   = 1'b1;
                        err_inc   = 1'b1;
                        sticky_d  = 1'b1;
                        bad_run_d = bad_nxt;
                        if (!sticky_q)
                            first_bad_d = {prev_q, s_in};
                        // Keep a known-good anchor when the sample is not a sequence value.
                        if (val_ok)
                            prev_d = s_in;
                        if (bad_nxt == BW'(ERR_THR))
                            state_d = LOST;
                    end
                end
                LOST: begin
                    if (s_in == SEQ_0) begin
                        state_d    = SYNC;
                        prev_d     = SEQ_0;
                        sync_run_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (clear) begin
            sticky_d    = 1'b0;
            first_bad_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            sync_run_q  <= '0;
            bad_run_q   <= '0;
            pulse_q     <= 1'b0;
            sticky_q    <= 1'b0;
            first_bad_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            sync_run_q  <= sync_run_d;
            bad_run_q   <= bad_run_d;
            pulse_q     <= pulse_d;
            sticky_q    <= sticky_d;
            first_bad_q <= first_bad_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (err_inc),
        .q     (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (lap_inc),
        .q     (lap_cnt)
    );

    assign lock       = (state_q == TRACK);
    assign err_pulse  = pulse_q;
    assign err_sticky = sticky_q;
    assign first_bad  = first_bad_q;
    assign state_o    = state_q;

endmodule
